// File: rtl/core_pkg.sv
// Shared decode types, opcode constants and helpers for the core pipeline.
// The id_ctrl_t bundle is the contract between decode and execute.
package core_pkg;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
        ALU_OR, ALU_AND, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
        ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
    } alu_op_e;

    typedef enum logic [1:0] {OPA_REG, OPA_PC, OPA_ZERO} op_a_sel_e;
    typedef enum logic       {OPB_REG, OPB_IMM} op_b_sel_e;
    typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

    typedef struct packed {
        alu_op_e    alu_op;
        op_a_sel_e  op_a_sel;
        op_b_sel_e  op_b_sel;
        logic       rd_we;
        logic       mem_re;
        logic       mem_we;
        logic [1:0] mem_size;
        logic       mem_unsigned;
        logic       branch;
        logic [2:0] branch_cond;
        logic       jal;
        logic       jalr;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } id_ctrl_t;

    localparam id_ctrl_t ID_CTRL_NOP = '{
        alu_op: ALU_ADD, op_a_sel: OPA_REG, op_b_sel: OPB_REG,
        rd_we: 1'b0, mem_re: 1'b0, mem_we: 1'b0, mem_size: 2'b00,
        mem_unsigned: 1'b0, branch: 1'b0, branch_cond: 3'b000,
        jal: 1'b0, jalr: 1'b0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0
    };

    function automatic alu_op_e base_op(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic alu_op_e m_op(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_MUL;
            3'b001:  return ALU_MULH;
            3'b010:  return ALU_MULHSU;
            3'b011:  return ALU_MULHU;
            3'b100:  return ALU_DIV;
            3'b101:  return ALU_DIVU;
            3'b110:  return ALU_REM;
            default: return ALU_REMU;
        endcase
    endfunction

endpackage

// File: rtl/core_imm_gen.sv
// Immediate generator: classifies the instruction format from the opcode
// and produces the sign-extended immediate (zero for formats without one).
module core_imm_gen
    import core_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     i_instr,
    output logic [XLEN-1:0] o_imm,
    output imm_fmt_e        o_fmt
);

    logic [31:0] w_imm32;

    always_comb begin
        case (i_instr[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: o_fmt = IMM_I;
            OPC_STORE:                      o_fmt = IMM_S;
            OPC_BRANCH:                     o_fmt = IMM_B;
            OPC_LUI, OPC_AUIPC:             o_fmt = IMM_U;
            OPC_JAL:                        o_fmt = IMM_J;
            default:                        o_fmt = IMM_NONE;
        endcase
    end

    always_comb begin
        case (o_fmt)
            IMM_I:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            IMM_S:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            IMM_B:   w_imm32 = {{20{i_instr[31]}}, i_instr[7], i_instr[30:25],
                                i_instr[11:8], 1'b0};
            IMM_U:   w_imm32 = {i_instr[31:12], 12'h000};
            IMM_J:   w_imm32 = {{12{i_instr[31]}}, i_instr[19:12], i_instr[20],
                                i_instr[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
    end

    assign o_imm = XLEN'($signed(w_imm32));

endmodule

// File: rtl/core_decode_stage.sv
// RV32I/E (+optional M) decode stage with a valid/ready output slice,
// optional 2-entry skid buffer and synchronous flush.
module core_decode_stage
    import core_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter bit          ENABLE_M   = 1'b0,
    parameter bit          SKID_EN    = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            if_valid_i,
    output logic            if_ready_o,
    input  logic [31:0]     if_instr_i,
    input  logic [XLEN-1:0] if_pc_i,
    output logic            ex_valid_o,
    input  logic            ex_ready_i,
    output id_ctrl_t        ex_ctrl_o,
    output logic [XLEN-1:0] ex_pc_o,
    output logic [XLEN-1:0] ex_imm_o,
    output logic            ex_illegal_o
);

    typedef struct packed {
        id_ctrl_t        ctrl;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } slot_t;

    localparam slot_t     SLOT_RST  = '{ctrl: ID_CTRL_NOP, pc: '0, imm: '0, illegal: 1'b0};
    localparam logic [5:0] REG_LIMIT = 6'(1 << REG_ADDR_W);

    logic [6:0]      w_opcode;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic [4:0]      w_rd;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [XLEN-1:0] w_imm;
    imm_fmt_e        w_imm_fmt;
    id_ctrl_t        w_ctrl;
    logic            w_bad;
    logic            w_reg_bad;
    logic            w_illegal;
    logic            w_use_rd;
    logic            w_use_rs1;
    logic            w_use_rs2;
    logic            w_accept;
    slot_t           w_in;
    slot_t           r_out;
    logic            r_out_valid;

    assign w_opcode = if_instr_i[6:0];
    assign w_rd     = if_instr_i[11:7];
    assign w_f3     = if_instr_i[14:12];
    assign w_rs1    = if_instr_i[19:15];
    assign w_rs2    = if_instr_i[24:20];
    assign w_f7     = if_instr_i[31:25];

    core_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .i_instr (if_instr_i),
        .o_imm   (w_imm),
        .o_fmt   (w_imm_fmt)
    );

    always_comb begin
        w_ctrl    = ID_CTRL_NOP;
        w_bad     = 1'b0;
        w_use_rd  = 1'b0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        case (w_opcode)
            OPC_LUI: begin
                w_use_rd        = 1'b1;
                w_ctrl.op_a_sel = OPA_ZERO;
            end
            OPC_AUIPC: begin
                w_use_rd        = 1'b1;
                w_ctrl.op_a_sel = OPA_PC;
            end
            OPC_JAL: begin
                w_use_rd        = 1'b1;
                w_ctrl.op_a_sel = OPA_PC;
                w_ctrl.jal      = 1'b1;
            end
            OPC_JALR: begin
                w_use_rd    = 1'b1;
                w_use_rs1   = 1'b1;
                w_ctrl.jalr = 1'b1;
                w_bad       = (w_f3 != 3'b000);
            end
            OPC_BRANCH: begin
                w_use_rs1          = 1'b1;
                w_use_rs2          = 1'b1;
                w_ctrl.branch      = 1'b1;
                w_ctrl.branch_cond = w_f3;
                w_bad              = (w_f3[2:1] == 2'b01);
            end
            OPC_LOAD: begin
                w_use_rd            = 1'b1;
                w_use_rs1           = 1'b1;
                w_ctrl.mem_re       = 1'b1;
                w_ctrl.mem_size     = w_f3[1:0];
                w_ctrl.mem_unsigned = w_f3[2];
                w_bad               = (w_f3 == 3'b011) || (w_f3[2:1] == 2'b11);
            end
            OPC_STORE: begin
                w_use_rs1           = 1'b1;
                w_use_rs2           = 1'b1;
                w_ctrl.mem_we       = 1'b1;
                w_ctrl.mem_size     = w_f3[1:0];
                w_ctrl.mem_unsigned = w_f3[2];
                w_bad               = w_f3[2] || (w_f3[1:0] == 2'b11);
            end
            OPC_OP_IMM: begin
                w_use_rd  = 1'b1;
                w_use_rs1 = 1'b1;
                case (w_f3)
                    3'b001: begin
                        if (w_f7 == 7'h00) w_ctrl.alu_op = ALU_SLL;
                        else               w_bad = 1'b1;
                    end
                    3'b101: begin
                        if (w_f7 == 7'h00)      w_ctrl.alu_op = ALU_SRL;
                        else if (w_f7 == 7'h20) w_ctrl.alu_op = ALU_SRA;
                        else                    w_bad = 1'b1;
                    end
                    default: w_ctrl.alu_op = base_op(w_f3);
                endcase
            end
            OPC_OP: begin
                w_use_rd  = 1'b1;
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                if (w_f7 == 7'h00)                         w_ctrl.alu_op = base_op(w_f3);
                else if (w_f7 == 7'h20 && w_f3 == 3'b000)  w_ctrl.alu_op = ALU_SUB;
                else if (w_f7 == 7'h20 && w_f3 == 3'b101)  w_ctrl.alu_op = ALU_SRA;
                else if (w_f7 == 7'h01 && ENABLE_M)        w_ctrl.alu_op = m_op(w_f3);
                else                                       w_bad = 1'b1;
            end
            OPC_MISC_MEM: ;
            default: w_bad = 1'b1;
        endcase

        // Branches compare two registers; every other immediate format feeds operand B.
        w_ctrl.op_b_sel = (w_imm_fmt != IMM_NONE && w_imm_fmt != IMM_B) ? OPB_IMM : OPB_REG;
        w_ctrl.rd       = w_use_rd  ? w_rd  : 5'd0;
        w_ctrl.rs1      = w_use_rs1 ? w_rs1 : 5'd0;
        w_ctrl.rs2      = w_use_rs2 ? w_rs2 : 5'd0;

        w_reg_bad = (w_use_rd  && ({1'b0, w_rd}  >= REG_LIMIT)) ||
                    (w_use_rs1 && ({1'b0, w_rs1} >= REG_LIMIT)) ||
                    (w_use_rs2 && ({1'b0, w_rs2} >= REG_LIMIT));
        w_illegal = w_bad || w_reg_bad;

        w_ctrl.rd_we = w_use_rd && (w_rd != 5'd0) && !w_illegal;
        if (w_illegal) begin
            w_ctrl.mem_re = 1'b0;
            w_ctrl.mem_we = 1'b0;
            w_ctrl.branch = 1'b0;
            w_ctrl.jal    = 1'b0;
            w_ctrl.jalr   = 1'b0;
        end
    end

    assign w_in     = '{ctrl: w_ctrl, pc: if_pc_i, imm: w_imm, illegal: w_illegal};
    assign w_accept = if_valid_i && if_ready_o;

    generate
        if (SKID_EN) begin : g_skid
            slot_t r_skid;
            logic  r_skid_valid;

            // The skid can only fill while the output is held, so an empty skid
            // guarantees room for one more instruction next cycle.
            assign if_ready_o = !r_skid_valid;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_out_valid  <= 1'b0;
                    r_out        <= SLOT_RST;
                    r_skid_valid <= 1'b0;
                    r_skid       <= SLOT_RST;
                end else if (flush_i) begin
                    r_out_valid  <= 1'b0;
                    r_skid_valid <= 1'b0;
                end else if (!r_out_valid || ex_ready_i) begin
                    if (r_skid_valid) begin
                        r_out        <= r_skid;
                        r_out_valid  <= 1'b1;
                        r_skid_valid <= 1'b0;
                    end else begin
                        r_out_valid <= w_accept;
                        if (w_accept) r_out <= w_in;
                    end
                end else if (w_accept) begin
                    r_skid       <= w_in;
                    r_skid_valid <= 1'b1;
                end
            end
        end else begin : g_noskid
            assign if_ready_o = !r_out_valid || ex_ready_i;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_out_valid <= 1'b0;
                    r_out       <= SLOT_RST;
                end else if (flush_i) begin
                    r_out_valid <= 1'b0;
                end else if (if_ready_o) begin
                    r_out_valid <= w_accept;
                    if (w_accept) r_out <= w_in;
                end
            end
        end
    endgenerate

    assign ex_valid_o   = r_out_valid;
    assign ex_ctrl_o    = r_out.ctrl;
    assign ex_pc_o      = r_out.pc;
    assign ex_imm_o     = r_out.imm;
    assign ex_illegal_o = r_out.illegal;

endmodule

// File: tb/tb_core_decode_stage.sv
// Two decode-stage configurations driven in lockstep and compared against
// an ISA-level decode model plus a queue model of the held instructions.
module tb_core_decode_stage;
    import core_pkg::*;

    typedef struct {
        id_ctrl_t    ctrl;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, flush, if_valid, ex_ready;
    logic [31:0] if_instr, if_pc;

    logic        a_if_ready, a_ex_valid, a_ill;
    id_ctrl_t    a_ctrl;
    logic [31:0] a_pc, a_imm;
    logic        b_if_ready, b_ex_valid, b_ill;
    id_ctrl_t    b_ctrl;
    logic [31:0] b_pc, b_imm;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;

    // A: RV32I, no M, skid buffer.  B: RV32E, M enabled, single register.
    core_decode_stage #(.XLEN(32), .REG_ADDR_W(5), .ENABLE_M(1'b0), .SKID_EN(1'b1)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .if_valid_i(if_valid),
        .if_ready_o(a_if_ready), .if_instr_i(if_instr), .if_pc_i(if_pc),
        .ex_valid_o(a_ex_valid), .ex_ready_i(ex_ready), .ex_ctrl_o(a_ctrl),
        .ex_pc_o(a_pc), .ex_imm_o(a_imm), .ex_illegal_o(a_ill)
    );

    core_decode_stage #(.XLEN(32), .REG_ADDR_W(4), .ENABLE_M(1'b1), .SKID_EN(1'b0)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .if_valid_i(if_valid),
        .if_ready_o(b_if_ready), .if_instr_i(if_instr), .if_pc_i(if_pc),
        .ex_valid_o(b_ex_valid), .ex_ready_i(ex_ready), .ex_ctrl_o(b_ctrl),
        .ex_pc_o(b_pc), .ex_imm_o(b_imm), .ex_illegal_o(b_ill)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic id_ctrl_t nop_ctrl();
        id_ctrl_t c;
        c          = '0;
        c.alu_op   = ALU_ADD;
        c.op_a_sel = OPA_REG;
        c.op_b_sel = OPB_REG;
        return c;
    endfunction

    // ISA-level decode: field meaning taken straight from the RV32 encoding tables.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                   input int unsigned regw, input bit en_m);
        exp_t        e;
        alu_op_e     base [8];
        alu_op_e     mop  [8];
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd, rs1, rs2;
        bit          urd, urs1, urs2, ill;
        base = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        mop  = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
        f3 = ins[14:12]; f7 = ins[31:25];
        rd = ins[11:7];  rs1 = ins[19:15]; rs2 = ins[24:20];
        urd = 0; urs1 = 0; urs2 = 0; ill = 0;
        e.ctrl = nop_ctrl(); e.pc = pc; e.imm = 32'd0;
        case (ins[6:0])
            7'h37: begin urd = 1; e.ctrl.op_a_sel = OPA_ZERO; e.ctrl.op_b_sel = OPB_IMM;
                         e.imm = {ins[31:12], 12'h000}; end
            7'h17: begin urd = 1; e.ctrl.op_a_sel = OPA_PC; e.ctrl.op_b_sel = OPB_IMM;
                         e.imm = {ins[31:12], 12'h000}; end
            7'h6F: begin urd = 1; e.ctrl.op_a_sel = OPA_PC; e.ctrl.op_b_sel = OPB_IMM;
                         e.ctrl.jal = 1;
                         e.imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0})); end
            7'h67: begin urd = 1; urs1 = 1; e.ctrl.op_b_sel = OPB_IMM; e.ctrl.jalr = 1;
                         e.imm = 32'($signed(ins[31:20])); ill = (f3 != 0); end
            7'h63: begin urs1 = 1; urs2 = 1; e.ctrl.branch = 1; e.ctrl.branch_cond = f3;
                         e.imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
                         ill = (f3 == 2 || f3 == 3); end
            7'h03: begin urd = 1; urs1 = 1; e.ctrl.op_b_sel = OPB_IMM; e.ctrl.mem_re = 1;
                         e.ctrl.mem_size = f3[1:0]; e.ctrl.mem_unsigned = f3[2];
                         e.imm = 32'($signed(ins[31:20])); ill = (f3 == 3 || f3 >= 6); end
            7'h23: begin urs1 = 1; urs2 = 1; e.ctrl.op_b_sel = OPB_IMM; e.ctrl.mem_we = 1;
                         e.ctrl.mem_size = f3[1:0]; e.ctrl.mem_unsigned = f3[2];
                         e.imm = 32'($signed({ins[31:25], ins[11:7]})); ill = (f3 >= 3); end
            7'h13: begin
                urd = 1; urs1 = 1; e.ctrl.op_b_sel = OPB_IMM;
                e.imm = 32'($signed(ins[31:20]));
                if (f3 == 1 || f3 == 5) begin
                    if (f7 == 0)                 e.ctrl.alu_op = base[f3];
                    else if (f3 == 5 && f7 == 32) e.ctrl.alu_op = ALU_SRA;
                    else                          ill = 1;
                end else e.ctrl.alu_op = base[f3];
            end
            7'h33: begin
                urd = 1; urs1 = 1; urs2 = 1;
                if (f7 == 0)                     e.ctrl.alu_op = base[f3];
                else if (f7 == 32 && f3 == 0)    e.ctrl.alu_op = ALU_SUB;
                else if (f7 == 32 && f3 == 5)    e.ctrl.alu_op = ALU_SRA;
                else if (f7 == 1 && en_m)        e.ctrl.alu_op = mop[f3];
                else                             ill = 1;
            end
            7'h0F: ;
            default: ill = 1;
        endcase
        if (regw == 4 && ((urd && rd >= 16) || (urs1 && rs1 >= 16) || (urs2 && rs2 >= 16)))
            ill = 1;
        e.ctrl.rd  = urd  ? rd  : 5'd0;
        e.ctrl.rs1 = urs1 ? rs1 : 5'd0;
        e.ctrl.rs2 = urs2 ? rs2 : 5'd0;
        e.ctrl.rd_we = urd && rd != 0 && !ill;
        if (ill) begin
            e.ctrl.mem_re = 0; e.ctrl.mem_we = 0; e.ctrl.branch = 0;
            e.ctrl.jal = 0; e.ctrl.jalr = 0;
        end
        e.ill = ill;
        return e;
    endfunction

    task automatic check_now();
        chk("a_ready", 64'(a_if_ready), 64'(qa.size() < 2));
        chk("a_valid", 64'(a_ex_valid), 64'(qa.size() > 0));
        if (qa.size() > 0) begin
            chk("a_ctrl", 64'(a_ctrl), 64'(qa[0].ctrl));
            chk("a_pc",   64'(a_pc),   64'(qa[0].pc));
            chk("a_imm",  64'(a_imm),  64'(qa[0].imm));
            chk("a_ill",  64'(a_ill),  64'(qa[0].ill));
        end
        chk("b_ready", 64'(b_if_ready), 64'(qb.size() == 0 || ex_ready));
        chk("b_valid", 64'(b_ex_valid), 64'(qb.size() > 0));
        if (qb.size() > 0) begin
            chk("b_ctrl", 64'(b_ctrl), 64'(qb[0].ctrl));
            chk("b_pc",   64'(b_pc),   64'(qb[0].pc));
            chk("b_imm",  64'(b_imm),  64'(qb[0].imm));
            chk("b_ill",  64'(b_ill),  64'(qb[0].ill));
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                        input bit fl, input bit rdy);
        bit acc_a, con_a, acc_b, con_b;
        if_valid = v; if_instr = ins; if_pc = pc; flush = fl; ex_ready = rdy;
        #1;
        check_now();
        acc_a = v && (qa.size() < 2);
        con_a = (qa.size() > 0) && rdy;
        acc_b = v && (qb.size() == 0 || rdy);
        con_b = (qb.size() > 0) && rdy;
        @(posedge clk);
        if (fl) begin
            qa.delete(); qb.delete();
        end else begin
            if (con_a) void'(qa.pop_front());
            if (acc_a) qa.push_back(model(ins, pc, 5, 1'b0));
            if (con_b) void'(qb.pop_front());
            if (acc_b) qb.push_back(model(ins, pc, 4, 1'b1));
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; if_valid = 1'b0; flush = 1'b0; ex_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        qa.delete(); qb.delete();
    endtask

    function automatic logic [31:0] addi(input int unsigned n);
        return {12'(n + 1), 5'd0, 3'b000, 5'(n + 1), 7'h13};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0]  opcs [11];
        int unsigned sel;
        opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
        w   = $urandom();
        sel = $urandom_range(0, 12);
        if (sel < 11) w[6:0] = opcs[sel];
        case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            2: w[31:25] = 7'h01;
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        int unsigned idx, emitted;
        bit          prev_hold, rdy, acc;
        logic [63:0] held;
        id_ctrl_t    nop;

        nop = nop_ctrl();
        if_instr = '0; if_pc = '0;
        @(negedge clk);
        do_reset();

        // reset state
        chk("rst_a_valid", 64'(a_ex_valid), 64'd0);
        chk("rst_a_ready", 64'(a_if_ready), 64'd1);
        chk("rst_a_ctrl",  64'(a_ctrl), 64'(nop));
        chk("rst_a_pc",    64'(a_pc), 64'd0);
        chk("rst_a_imm",   64'(a_imm), 64'd0);
        chk("rst_a_ill",   64'(a_ill), 64'd0);
        chk("rst_b_valid", 64'(b_ex_valid), 64'd0);

        // ADDI x5, x1, -1
        step(1'b1, 32'hFFF08293, 32'h100, 1'b0, 1'b1);
        chk("t1_valid", 64'(a_ex_valid), 64'd1);
        chk("t1_alu",   64'(a_ctrl.alu_op), 64'(ALU_ADD));
        chk("t1_opb",   64'(a_ctrl.op_b_sel), 64'(OPB_IMM));
        chk("t1_rd",    64'(a_ctrl.rd), 64'd5);
        chk("t1_rs1",   64'(a_ctrl.rs1), 64'd1);
        chk("t1_imm",   64'(a_imm), 64'hFFFF_FFFF);
        chk("t1_rdwe",  64'(a_ctrl.rd_we), 64'd1);

        // SW x2, -4(x3)
        step(1'b1, 32'hFE21AE23, 32'h104, 1'b0, 1'b1);
        chk("t2_memwe", 64'(a_ctrl.mem_we), 64'd1);
        chk("t2_rdwe",  64'(a_ctrl.rd_we), 64'd0);
        chk("t2_imm",   64'(a_imm), 64'hFFFF_FFFC);
        chk("t2_size",  64'(a_ctrl.mem_size), 64'd2);

        // MUL x1, x2, x3
        step(1'b1, 32'h023100B3, 32'h108, 1'b0, 1'b1);
        chk("t5_a_ill",  64'(a_ill), 64'd1);
        chk("t5_a_rdwe", 64'(a_ctrl.rd_we), 64'd0);
        chk("t5_b_alu",  64'(b_ctrl.alu_op), 64'(ALU_MUL));
        chk("t5_b_ill",  64'(b_ill), 64'd0);

        // SRAI x4, x4, 3 then ADD x17, x0, x0
        step(1'b1, 32'h40325213, 32'h10C, 1'b0, 1'b1);
        chk("t6_alu",   64'(a_ctrl.alu_op), 64'(ALU_SRA));
        chk("t6_shamt", 64'(a_imm[4:0]), 64'd3);
        step(1'b1, 32'h000008B3, 32'h110, 1'b0, 1'b1);
        chk("t6_a_ill", 64'(a_ill), 64'd0);
        chk("t6_b_ill", 64'(b_ill), 64'd1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // four ADDIs with execute stalled for three cycles
        idx = 0; emitted = 0; prev_hold = 0; held = '0;
        for (int k = 0; k < 12; k++) begin
            rdy = !(k >= 1 && k <= 3);
            if (prev_hold) chk("t3_hold", {a_pc, a_imm}, held);
            if (a_ex_valid && rdy) begin
                chk("t3_order", 64'(a_pc), 64'(32'h200 + 4 * emitted));
                emitted++;
            end
            prev_hold = a_ex_valid && !rdy;
            held      = {a_pc, a_imm};
            acc       = (idx < 4) && a_if_ready;
            step(idx < 4, addi(idx), 32'h200 + 4 * idx, 1'b0, rdy);
            if (acc) begin
                idx++;
                if (idx == 1) chk("t3_ready_after_1", 64'(a_if_ready), 64'd1);
                if (idx == 2) chk("t3_ready_drop", 64'(a_if_ready), 64'd0);
            end
        end
        chk("t3_count", 64'(emitted), 64'd4);

        // output + skid occupied, then flush with a valid offer
        step(1'b1, addi(0), 32'h300, 1'b0, 1'b1);
        step(1'b1, addi(1), 32'h304, 1'b0, 1'b0);
        chk("t4_full", 64'(a_if_ready), 64'd0);
        step(1'b1, addi(2), 32'h308, 1'b1, 1'b0);
        chk("t4_a_flushed", 64'(a_ex_valid), 64'd0);
        chk("t4_b_flushed", 64'(b_ex_valid), 64'd0);
        step(1'b1, addi(3), 32'h30C, 1'b0, 1'b1);
        chk("t4_next_pc", 64'(a_pc), 64'h30C);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("t4_alone", 64'(a_ex_valid), 64'd0);

        // flush wins over an accept into an empty slice
        step(1'b1, addi(4), 32'h400, 1'b1, 1'b1);
        chk("t4_flush_accept_a", 64'(a_ex_valid), 64'd0);
        chk("t4_flush_accept_b", 64'(b_ex_valid), 64'd0);

        // reset mid-stream drops held instructions
        step(1'b1, addi(5), 32'h500, 1'b0, 1'b0);
        step(1'b1, addi(6), 32'h504, 1'b0, 1'b0);
        do_reset();
        chk("rst_mid_a_valid", 64'(a_ex_valid), 64'd0);
        chk("rst_mid_a_ready", 64'(a_if_ready), 64'd1);
        chk("rst_mid_b_valid", 64'(b_ex_valid), 64'd0);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 3) != 0, rand_instr(), $urandom(),
                 $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7);
        end
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
